adc_cfg_seq: RTL and testbench



---
 rtl/adc_cfg_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_adc_cfg_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cfg_seq.sv
// ADC configuration sequencer: plays a 4-entry init table, then serves host single accesses
// through a strobed command word. Define ADC_CFG_VERIFY_EN to read back and check each init write.
module adc_cfg_seq #(
    parameter int unsigned RST_CYC   = 64,
    parameter int unsigned SETUP_CYC = 16,
    parameter int unsigned HOLD_CYC  = 320,
    parameter int unsigned GAP_CYC   = 64,
    parameter logic [22:0] INIT0     = 23'h00_0001,
    parameter logic [22:0] INIT1     = 23'h01_0000,
    parameter logic [22:0] INIT2     = 23'h02_0080,
    parameter logic [22:0] INIT3     = 23'h03_00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        host_cmd_valid,
    input  logic [31:0] host_cmd,
    output logic        host_cmd_ready,
    output logic [31:0] cmd_out,
    input  logic [31:0] rd_data_in,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        init_done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        ADC_RST,
        SETUP,
        STROBE,
        GAP
`ifdef ADC_CFG_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    // Counters are loaded with N-1 on state entry so each state lasts exactly N cycles.
    localparam logic [9:0]  RST_LD    = 10'(RST_CYC - 1);
    localparam logic [9:0]  SETUP_LD  = 10'(SETUP_CYC - 1);
    localparam logic [9:0]  HOLD_LD   = 10'(HOLD_CYC - 1);
    localparam logic [9:0]  GAP_LD    = 10'(GAP_CYC - 1);
    localparam logic [31:0] IDLE_WORD = 32'h0000_0004;

    function automatic logic [22:0] init_entry(input logic [1:0] i);
        case (i)
            2'd0:    return INIT0;
            2'd1:    return INIT1;
            2'd2:    return INIT2;
            default: return INIT3;
        endcase
    endfunction

    function automatic logic [31:0] make_word(input logic [15:0] d, input logic [6:0] a,
                                              input logic rw, input logic stb);
        return {d, 1'b0, a, 5'b0_0000, 1'b1, rw, stb};
    endfunction

    state_t      state, state_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        init_mode, init_mode_nxt;
    logic [15:0] acc_data, acc_data_nxt;
    logic [6:0]  acc_addr, acc_addr_nxt;
    logic        acc_rw, acc_rw_nxt;
    logic [31:0] cmd_nxt;
    logic [15:0] rd_data_nxt;
    logic        rd_valid_nxt, init_done_nxt;
    logic        go_setup, advance;
    logic [15:0] set_data;
    logic [6:0]  set_addr;
    logic        set_rw;
    logic [22:0] next_entry;
`ifdef ADC_CFG_VERIFY_EN
    logic        rd_phase, rd_phase_nxt;
    logic        err_q, err_nxt;
`endif

    logic unused_bits;
    assign unused_bits = ^{rd_data_in[31:16], host_cmd[15], host_cmd[7:2], host_cmd[0]};

    assign busy           = (state != IDLE);
    assign host_cmd_ready = (state == IDLE) && !start;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = (cnt != '0) ? cnt - 10'd1 : cnt;
        idx_nxt       = idx;
        init_mode_nxt = init_mode;
        acc_data_nxt  = acc_data;
        acc_addr_nxt  = acc_addr;
        acc_rw_nxt    = acc_rw;
        cmd_nxt       = cmd_out;
        rd_data_nxt   = rd_data;
        rd_valid_nxt  = 1'b0;
        init_done_nxt = init_done;
        go_setup      = 1'b0;
        advance       = 1'b0;
        set_data      = acc_data;
        set_addr      = acc_addr;
        set_rw        = acc_rw;
        next_entry    = init_entry(idx + 2'd1);
`ifdef ADC_CFG_VERIFY_EN
        rd_phase_nxt  = rd_phase;
        err_nxt       = err_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = ADC_RST;
                    cnt_nxt       = RST_LD;
                    cmd_nxt       = '0;
                    idx_nxt       = '0;
                    init_mode_nxt = 1'b1;
                    init_done_nxt = 1'b0;
`ifdef ADC_CFG_VERIFY_EN
                    rd_phase_nxt  = 1'b0;
                    err_nxt       = 1'b0;
`endif
                end else if (host_cmd_valid) begin
                    go_setup      = 1'b1;
                    set_data      = host_cmd[31:16];
                    set_addr      = host_cmd[14:8];
                    set_rw        = host_cmd[1];
                    init_mode_nxt = 1'b0;
                end
            end
            ADC_RST: begin
                if (cnt == '0) begin
                    go_setup              = 1'b1;
                    {set_addr, set_data}  = init_entry(idx);
                    set_rw                = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = HOLD_LD;
                    cmd_nxt   = make_word(acc_data, acc_addr, acc_rw, 1'b1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                    cmd_nxt   = make_word(acc_data, acc_addr, acc_rw, 1'b0);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    rd_data_nxt = rd_data_in[15:0];
                    if (!init_mode) begin
                        rd_valid_nxt = acc_rw;
                        state_nxt    = IDLE;
                        cmd_nxt      = IDLE_WORD;
                    end
`ifdef ADC_CFG_VERIFY_EN
                    else if (!rd_phase) begin
                        // Read back the entry just written; data field is left as written.
                        rd_phase_nxt = 1'b1;
                        go_setup     = 1'b1;
                        set_rw       = 1'b1;
                    end else begin
                        rd_phase_nxt = 1'b0;
                        rd_valid_nxt = 1'b1;
                        state_nxt    = VERIFY;
                    end
`else
                    else begin
                        advance = 1'b1;
                    end
`endif
                end
            end
`ifdef ADC_CFG_VERIFY_EN
            VERIFY: begin
                if (rd_data != acc_data) err_nxt = 1'b1;
                advance = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (advance) begin
            if (idx == 2'd3) begin
                state_nxt     = IDLE;
                init_done_nxt = 1'b1;
                init_mode_nxt = 1'b0;
                cmd_nxt       = IDLE_WORD;
            end else begin
                idx_nxt              = idx + 2'd1;
                go_setup             = 1'b1;
                {set_addr, set_data} = next_entry;
                set_rw               = 1'b0;
            end
        end

        if (go_setup) begin
            state_nxt    = SETUP;
            cnt_nxt      = SETUP_LD;
            acc_data_nxt = set_data;
            acc_addr_nxt = set_addr;
            acc_rw_nxt   = set_rw;
            cmd_nxt      = make_word(set_data, set_addr, set_rw, 1'b0);
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates land together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            init_mode <= 1'b0;
            acc_data  <= '0;
            acc_addr  <= '0;
            acc_rw    <= 1'b0;
            cmd_out   <= IDLE_WORD;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            init_done <= 1'b0;
`ifdef ADC_CFG_VERIFY_EN
            rd_phase  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            init_mode <= init_mode_nxt;
            acc_data  <= acc_data_nxt;
            acc_addr  <= acc_addr_nxt;
            acc_rw    <= acc_rw_nxt;
            cmd_out   <= cmd_nxt;
            rd_data   <= rd_data_nxt;
            rd_valid  <= rd_valid_nxt;
            init_done <= init_done_nxt;
`ifdef ADC_CFG_VERIFY_EN
            rd_phase  <= rd_phase_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

`ifdef ADC_CFG_VERIFY_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Self-checking bench for adc_cfg_seq: per-cycle expected command-word timeline built from the
// access rules, compared against the DUT for init, host accesses, collisions and reset abort.
`timescale 1ns/1ps
module tb_adc_cfg_seq;

    localparam int RST_CYC   = 64;
    localparam int SETUP_CYC = 16;
    localparam int HOLD_CYC  = 320;
    localparam int GAP_CYC   = 64;
    localparam int ACC_CYC   = SETUP_CYC + HOLD_CYC + GAP_CYC;
`ifdef ADC_CFG_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif
    localparam int ENTRY_CYC = VERIFY_ON ? (2 * ACC_CYC + 1) : ACC_CYC;

    logic [22:0] init_tab [4] = '{23'h00_0001, 23'h01_0000, 23'h02_0080, 23'h03_00FF};

    logic        clk, reset, start, host_cmd_valid, host_cmd_ready;
    logic [31:0] host_cmd, cmd_out, rd_data_in;
    logic [15:0] rd_data;
    logic        rd_valid, busy, init_done, err;

    adc_cfg_seq dut (
        .clk(clk), .reset(reset), .start(start), .host_cmd_valid(host_cmd_valid),
        .host_cmd(host_cmd), .host_cmd_ready(host_cmd_ready), .cmd_out(cmd_out),
        .rd_data_in(rd_data_in), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .init_done(init_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_init_done = 1'b0;

    logic [31:0] exp_cmd [$];
    bit          exp_rv  [$];

    function automatic logic [31:0] word(input logic [15:0] d, input logic [6:0] a,
                                         input logic rw, input logic stb);
        return {d, 1'b0, a, 5'b0_0000, 1'b1, rw, stb};
    endfunction

    function automatic void push_n(input logic [31:0] w, input int n, input bit rv);
        for (int i = 0; i < n; i++) begin
            exp_cmd.push_back(w);
            exp_rv.push_back(rv);
        end
    endfunction

    function automatic void push_access(input logic [15:0] d, input logic [6:0] a, input logic rw);
        push_n(word(d, a, rw, 1'b0), SETUP_CYC, 1'b0);
        push_n(word(d, a, rw, 1'b1), HOLD_CYC, 1'b0);
        push_n(word(d, a, rw, 1'b0), GAP_CYC, 1'b0);
    endfunction

    // Expected init timeline; returns whether readback verification should flag an error.
    function automatic bit build_init(input logic [15:0] rb);
        bit e_err = 1'b0;
        exp_cmd.delete();
        exp_rv.delete();
        push_n(32'h0, RST_CYC, 1'b0);
        for (int e = 0; e < 4; e++) begin
            logic [15:0] d = init_tab[e][15:0];
            logic [6:0]  a = init_tab[e][22:16];
            push_access(d, a, 1'b0);
            if (VERIFY_ON) begin
                push_access(d, a, 1'b1);
                push_n(word(d, a, 1'b1, 1'b0), 1, 1'b1);
                if (rb != d) e_err = 1'b1;
            end
        end
        return e_err;
    endfunction

    task automatic run_trace(input string name, input int poke_at, input logic [31:0] poke_cmd);
        int bad_cmd = 0, bad_busy = 0, bad_rv = 0, first = -1;
        logic [31:0] f_got = '0, f_exp = '0;
        for (int i = 0; i < exp_cmd.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                host_cmd_valid = 1'b0;
            end
            if (i == poke_at) begin
                start = 1'b1;
                host_cmd_valid = 1'b1;
                host_cmd = poke_cmd;
            end else if (i == poke_at + 1) begin
                start = 1'b0;
                host_cmd_valid = 1'b0;
            end
            if (cmd_out !== exp_cmd[i]) begin
                if (first < 0) begin
                    first = i;
                    f_got = cmd_out;
                    f_exp = exp_cmd[i];
                end
                bad_cmd++;
            end
            if (busy !== 1'b1) bad_busy++;
            if (rd_valid !== exp_rv[i]) bad_rv++;
        end
        n_checks++;
        if (bad_cmd != 0)
            $display("FAIL %s cmd_out trace: %0d bad cycles, first at %0d got %h expected %h",
                     name, bad_cmd, first, f_got, f_exp);
        else n_pass++;
        n_checks++;
        if (bad_busy != 0) $display("FAIL %s busy trace: %0d cycles low, expected 0", name, bad_busy);
        else n_pass++;
        n_checks++;
        if (bad_rv != 0) $display("FAIL %s rd_valid trace: %0d bad cycles, expected 0", name, bad_rv);
        else n_pass++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        host_cmd_valid = 1'b0;
        host_cmd = '0;
        rd_data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_init_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset cmd_out", cmd_out, 32'h0000_0004);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset host_cmd_ready", {31'b0, host_cmd_ready}, 32'd1);
        chk("reset init_done", {31'b0, init_done}, 32'd0);
        chk("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset rd_data", {16'b0, rd_data}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
    endtask

    task automatic test_init(input string name, input logic [15:0] rb);
        bit e_err;
        rd_data_in = {16'($urandom()), rb};
        @(negedge clk);
        start = 1'b1;
        e_err = build_init(rb);
        run_trace(name, -1, '0);
        model_init_done = 1'b1;
        @(negedge clk);
        chk({name, " init_done"}, {31'b0, init_done}, 32'd1);
        chk({name, " busy"}, {31'b0, busy}, 32'd0);
        chk({name, " idle cmd_out"}, cmd_out, 32'h0000_0004);
        chk({name, " err"}, {31'b0, err}, {31'b0, e_err});
        chk({name, " rd_data"}, {16'b0, rd_data}, {16'b0, rb});
        chk({name, " rd_valid"}, {31'b0, rd_valid}, 32'd0);
    endtask

    task automatic test_host(input string name, input logic [31:0] cmd, input logic [15:0] rb);
        rd_data_in = {16'($urandom()), rb};
        @(negedge clk);
        host_cmd = cmd;
        host_cmd_valid = 1'b1;
        #1;
        chk({name, " ready"}, {31'b0, host_cmd_ready}, 32'd1);
        exp_cmd.delete();
        exp_rv.delete();
        push_access(cmd[31:16], cmd[14:8], cmd[1]);
        // start and a different command mid-access must both be ignored
        run_trace(name, 100, ~cmd);
        @(negedge clk);
        chk({name, " rd_valid"}, {31'b0, rd_valid}, {31'b0, cmd[1]});
        chk({name, " rd_data"}, {16'b0, rd_data}, {16'b0, rb});
        chk({name, " busy"}, {31'b0, busy}, 32'd0);
        chk({name, " init_done kept"}, {31'b0, init_done}, {31'b0, model_init_done});
        @(negedge clk);
        chk({name, " rd_valid one cycle"}, {31'b0, rd_valid}, 32'd0);
    endtask

    task automatic test_random_host();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] c = $urandom();
            c[1] = i[0];
            test_host($sformatf("rand_host%0d", i), c, 16'($urandom()));
        end
    endtask

    task automatic test_collision();
        bit e_err;
        logic [15:0] rb = 16'($urandom());
        rd_data_in = {16'h0, rb};
        @(negedge clk);
        start = 1'b1;
        host_cmd_valid = 1'b1;
        host_cmd = 32'h0000_2A02;
        #1;
        chk("collision ready", {31'b0, host_cmd_ready}, 32'd0);
        e_err = build_init(rb);
        run_trace("collision", -1, '0);
        @(negedge clk);
        chk("collision init_done", {31'b0, init_done}, 32'd1);
        chk("collision err", {31'b0, err}, {31'b0, e_err});
        repeat (3) @(negedge clk);
        chk("collision no host access", {31'b0, busy}, 32'd0);
    endtask

    task automatic test_reset_mid_strobe();
        bit e_err;
        int target = RST_CYC + 2 * ENTRY_CYC + SETUP_CYC + 7;
        @(negedge clk);
        start = 1'b1;
        e_err = build_init(16'h0);
        for (int i = 0; i <= target; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        chk("mid_strobe precondition", cmd_out, exp_cmd[target]);
        reset = 1'b1;
        #1;
        chk("mid_strobe cmd_out", cmd_out, 32'h0000_0004);
        chk("mid_strobe busy", {31'b0, busy}, 32'd0);
        chk("mid_strobe init_done", {31'b0, init_done}, 32'd0);
        chk("mid_strobe err", {31'b0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_init_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_strobe not retried busy", {31'b0, busy}, 32'd0);
        chk("mid_strobe not retried cmd_out", cmd_out, 32'h0000_0004);
    endtask

    initial begin
        test_reset();
        test_init("init", 16'($urandom()));
        test_host("host_read", 32'h0000_2A02, 16'hBEEF);
        test_random_host();
        test_collision();
        test_init("init_rb_zero", 16'h0000);
        test_reset_mid_strobe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
